// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit: MULT, MULTU, DIV, DIVU into HI/LO.
// One radix-2 step per cycle (shift-add multiply, restoring divide) on operand
// magnitudes; signs are re-applied in a final FIX cycle.
module mult_div_unit #(
  parameter int unsigned WIDTH     = 32,
  parameter bit          DIVZ_HOLD = 1'b1
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] oper_A,
  input  logic [WIDTH-1:0] oper_B,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             is_div_q, is_div_d;
  logic             neg_q_q, neg_q_d;   // product / quotient sign
  logic             neg_r_q, neg_r_d;   // remainder sign (dividend sign)
  logic             zflag_q, zflag_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] b_mag_q, b_mag_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;  // running product high / partial remainder
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;  // multiplier bits / dividend->quotient bits
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;

  // Operand magnitudes and result signs at acceptance time.
  logic             is_signed;
  logic [WIDTH-1:0] a_abs, b_abs;
  always_comb begin
    is_signed = ~op[0];
    a_abs     = (is_signed && oper_A[WIDTH-1]) ? -oper_A : oper_A;
    b_abs     = (is_signed && oper_B[WIDTH-1]) ? -oper_B : oper_B;
  end

  // Single iteration datapath for both multiply and divide.
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod;
  always_comb begin
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, b_mag_q} : '0);
    div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_mag_q};
    div_ge    = (div_shift >= {1'b0, b_mag_q});
    prod      = {acc_hi_q, acc_lo_q};
  end

  // Next-state logic for the IDLE -> CALC -> FIX -> IDLE sequence.
  always_comb begin
    state_d  = state_q;
    is_div_d = is_div_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    zflag_d  = zflag_q;
    cnt_d    = cnt_q;
    b_mag_d  = b_mag_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dz_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          is_div_d = op[1];
          neg_q_d  = is_signed & (oper_A[WIDTH-1] ^ oper_B[WIDTH-1]);
          neg_r_d  = is_signed & oper_A[WIDTH-1];
          cnt_d    = CW'(WIDTH);
          b_mag_d  = b_abs;
          acc_lo_d = a_abs;
          if (op[1] && (oper_B == '0)) begin
            // Keep the raw dividend for the non-hold divide-by-zero result.
            zflag_d  = 1'b1;
            acc_hi_d = oper_A;
            state_d  = FIX;
          end else begin
            zflag_d  = 1'b0;
            acc_hi_d = '0;
            state_d  = CALC;
          end
        end
      end
      CALC: begin
        if (is_div_q) begin
          acc_hi_d = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
          acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ge};
        end else begin
          acc_hi_d = mul_sum[WIDTH:1];
          acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (zflag_q) begin
          dz_d = 1'b1;
          if (!DIVZ_HOLD) begin
            hi_d = acc_hi_q;
            lo_d = '1;
          end
        end else if (is_div_q) begin
          lo_d = neg_q_q ? -acc_lo_q : acc_lo_q;
          hi_d = neg_r_q ? -acc_hi_q : acc_hi_q;
        end else begin
          {hi_d, lo_d} = neg_q_q ? -prod : prod;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset; reset abandons any operation.
  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q  <= IDLE;
      is_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      zflag_q  <= 1'b0;
      cnt_q    <= '0;
      b_mag_q  <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_div_q <= is_div_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      zflag_q  <= zflag_d;
      cnt_q    <= cnt_d;
      b_mag_q  <= b_mag_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
    end
  end

  // Outputs: busy covers CALC and FIX, so it is already low in the done cycle.
  always_comb begin
    busy     = (state_q != IDLE);
    done     = done_q;
    div_zero = dz_q;
    hi       = hi_q;
    lo       = lo_q;
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit.
// DUT a: WIDTH=32 hold-on-div-zero; DUT b: WIDTH=32 non-hold; DUT c: WIDTH=8.
module tb_mult_div_unit;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  logic Clk = 1'b0;
  logic reset;

  logic        start_a, busy_a, done_a, dz_a;
  logic [1:0]  op_a;
  logic [31:0] a_a, b_a, hi_a, lo_a;

  logic        start_b, busy_b, done_b, dz_b;
  logic [1:0]  op_b;
  logic [31:0] a_b, b_b, hi_b, lo_b;

  logic        start_c, busy_c, done_c, dz_c;
  logic [1:0]  op_c;
  logic [7:0]  a_c, b_c, hi_c, lo_c;

  int errors = 0;
  int checks = 0;

  always #5 Clk = ~Clk;

  mult_div_unit #(.WIDTH(32), .DIVZ_HOLD(1'b1)) u_dut_a (
    .Clk(Clk), .reset(reset), .start(start_a), .op(op_a), .oper_A(a_a), .oper_B(b_a),
    .busy(busy_a), .done(done_a), .div_zero(dz_a), .hi(hi_a), .lo(lo_a)
  );

  mult_div_unit #(.WIDTH(32), .DIVZ_HOLD(1'b0)) u_dut_b (
    .Clk(Clk), .reset(reset), .start(start_b), .op(op_b), .oper_A(a_b), .oper_B(b_b),
    .busy(busy_b), .done(done_b), .div_zero(dz_b), .hi(hi_b), .lo(lo_b)
  );

  mult_div_unit #(.WIDTH(8), .DIVZ_HOLD(1'b1)) u_dut_c (
    .Clk(Clk), .reset(reset), .start(start_c), .op(op_c), .oper_A(a_c), .oper_B(b_c),
    .busy(busy_c), .done(done_c), .div_zero(dz_c), .hi(hi_c), .lo(lo_c)
  );

  task automatic drive(input int d, input logic s, input logic [1:0] o,
                       input logic [31:0] x, input logic [31:0] y);
    case (d)
      0: begin start_a = s; op_a = o; a_a = x; b_a = y; end
      1: begin start_b = s; op_b = o; a_b = x; b_b = y; end
      default: begin start_c = s; op_c = o; a_c = x[7:0]; b_c = y[7:0]; end
    endcase
  endtask

  // Returns at the falling edge right after the accepting edge E0.
  task automatic launch(input int d, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y);
    @(negedge Clk);
    drive(d, 1'b1, o, x, y);
    @(negedge Clk);
    drive(d, 1'b0, o, x, y);
  endtask

  function automatic logic done_of(input int d);
    case (d)
      0: done_of = done_a;
      1: done_of = done_b;
      default: done_of = done_c;
    endcase
  endfunction

  // k = number of rising edges after E0 at which done is first seen (bounded).
  task automatic wait_done(input int d, output int k);
    k = 0;
    while (!done_of(d) && k < 200) begin
      @(negedge Clk);
      k++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    drive(0, 1'b0, 2'b00, 32'h0, 32'h0);
    drive(1, 1'b0, 2'b00, 32'h0, 32'h0);
    drive(2, 1'b0, 2'b00, 32'h0, 32'h0);
    repeat (3) @(negedge Clk);
    reset = 1'b0;
    @(negedge Clk);
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b want=0", busy_a); end
    checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b want=0", done_a); end
    checks++; if (dz_a !== 1'b0) begin errors++; $display("FAIL reset_divzero got=%0b want=0", dz_a); end
    checks++; if ({hi_a, lo_a} !== 64'h0) begin
      errors++; $display("FAIL reset_hilo got=%h_%h want=0_0", hi_a, lo_a);
    end
  endtask

  task automatic test_multu;
    int k;
    launch(0, OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(0, k);
    checks++; if (k != 33) begin errors++; $display("FAIL multu_latency got=%0d want=33", k); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL multu_busy_at_done got=%0b want=0", busy_a); end
    checks++; if (hi_a !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_hi got=%h want=fffffffe", hi_a); end
    checks++; if (lo_a !== 32'h00000001) begin errors++; $display("FAIL multu_lo got=%h want=00000001", lo_a); end
  endtask

  task automatic test_mult_signed;
    int k;
    launch(0, OP_MULT, 32'hFFFFFFFD, 32'd5);
    wait_done(0, k);
    checks++; if ({hi_a, lo_a} !== 64'hFFFFFFFF_FFFFFFF1) begin
      errors++; $display("FAIL mult_neg3x5 got=%h_%h want=ffffffff_fffffff1", hi_a, lo_a);
    end
    launch(0, OP_MULT, 32'hFFFFFFFC, 32'hFFFFFFFC);
    wait_done(0, k);
    checks++; if ({hi_a, lo_a} !== 64'h00000000_00000010) begin
      errors++; $display("FAIL mult_neg4xneg4 got=%h_%h want=00000000_00000010", hi_a, lo_a);
    end
  endtask

  task automatic test_div;
    int k;
    launch(0, OP_DIV, 32'hFFFFFFF9, 32'd2);
    wait_done(0, k);
    checks++; if ({hi_a, lo_a} !== 64'hFFFFFFFF_FFFFFFFD) begin
      errors++; $display("FAIL div_neg7by2 got=%h_%h want=ffffffff_fffffffd", hi_a, lo_a);
    end
    checks++; if (dz_a !== 1'b0) begin errors++; $display("FAIL div_no_zflag got=%0b want=0", dz_a); end
    launch(0, OP_DIVU, 32'd7, 32'd2);
    wait_done(0, k);
    checks++; if (k != 33) begin errors++; $display("FAIL divu_latency got=%0d want=33", k); end
    checks++; if ({hi_a, lo_a} !== 64'h00000001_00000003) begin
      errors++; $display("FAIL divu_7by2 got=%h_%h want=00000001_00000003", hi_a, lo_a);
    end
    launch(0, OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_done(0, k);
    checks++; if ({hi_a, lo_a} !== 64'h00000000_80000000) begin
      errors++; $display("FAIL div_minbyneg1 got=%h_%h want=00000000_80000000", hi_a, lo_a);
    end
  endtask

  task automatic test_div_zero;
    int k;
    launch(0, OP_DIVU, 32'd5, 32'd2);
    wait_done(0, k);
    checks++; if ({hi_a, lo_a} !== 64'h00000001_00000002) begin
      errors++; $display("FAIL divz_prep got=%h_%h want=00000001_00000002", hi_a, lo_a);
    end
    launch(0, OP_DIVU, 32'd9, 32'd0);
    wait_done(0, k);
    checks++; if (k != 1) begin errors++; $display("FAIL divz_latency got=%0d want=1", k); end
    checks++; if (dz_a !== 1'b1) begin errors++; $display("FAIL divz_flag got=%0b want=1", dz_a); end
    checks++; if ({hi_a, lo_a} !== 64'h00000001_00000002) begin
      errors++; $display("FAIL divz_hold got=%h_%h want=00000001_00000002", hi_a, lo_a);
    end
    @(negedge Clk);
    checks++; if ({done_a, dz_a} !== 2'b00) begin
      errors++; $display("FAIL divz_pulse got=%b want=00", {done_a, dz_a});
    end
    launch(1, OP_DIVU, 32'd9, 32'd0);
    wait_done(1, k);
    checks++; if (k != 1 || dz_b !== 1'b1 || busy_b !== 1'b0) begin
      errors++; $display("FAIL divz_nohold_flag got=k%0d dz%0b busy%0b want=k1 dz1 busy0", k, dz_b, busy_b);
    end
    checks++; if ({hi_b, lo_b} !== 64'h00000009_FFFFFFFF) begin
      errors++; $display("FAIL divz_nohold got=%h_%h want=00000009_ffffffff", hi_b, lo_b);
    end
  endtask

  task automatic test_busy_ignore;
    int ndone = 0;
    int first = -1;
    int overlap = 0;
    launch(0, OP_MULTU, 32'd3, 32'd4);
    for (int k = 1; k <= 60; k++) begin
      @(negedge Clk);
      if (k == 5) drive(0, 1'b1, OP_DIVU, 32'd100, 32'd7);
      else if (k == 6) drive(0, 1'b0, OP_DIVU, 32'd100, 32'd7);
      if (done_a) begin
        ndone++;
        if (first < 0) first = k;
      end
      if (done_a && busy_a) overlap++;
    end
    checks++; if (ndone != 1) begin errors++; $display("FAIL busy_ignore_count got=%0d want=1", ndone); end
    checks++; if (first != 33) begin errors++; $display("FAIL busy_ignore_latency got=%0d want=33", first); end
    checks++; if ({hi_a, lo_a} !== 64'h00000000_0000000C) begin
      errors++; $display("FAIL busy_ignore_result got=%h_%h want=00000000_0000000c", hi_a, lo_a);
    end
    checks++; if (overlap != 0) begin errors++; $display("FAIL done_busy_overlap got=%0d want=0", overlap); end
  endtask

  task automatic test_back_to_back;
    int k;
    launch(0, OP_MULTU, 32'd6, 32'd7);
    wait_done(0, k);
    checks++; if (k != 33 || lo_a !== 32'd42) begin
      errors++; $display("FAIL b2b_first got=k%0d lo%h want=k33 lo0000002a", k, lo_a);
    end
    // Start issued during the done cycle.
    drive(0, 1'b1, OP_DIVU, 32'd100, 32'd7);
    @(negedge Clk);
    drive(0, 1'b0, OP_DIVU, 32'd100, 32'd7);
    wait_done(0, k);
    checks++; if (k != 33) begin errors++; $display("FAIL b2b_latency got=%0d want=33", k); end
    checks++; if ({hi_a, lo_a} !== 64'h00000002_0000000E) begin
      errors++; $display("FAIL b2b_second got=%h_%h want=00000002_0000000e", hi_a, lo_a);
    end
  endtask

  task automatic test_reset_mid;
    int ndone = 0;
    launch(0, OP_MULT, 32'hFFFFFFFD, 32'd5);
    repeat (10) @(negedge Clk);
    reset = 1'b1;
    @(negedge Clk);
    checks++; if ({busy_a, done_a} !== 2'b00) begin
      errors++; $display("FAIL reset_mid_busy got=%b want=00", {busy_a, done_a});
    end
    checks++; if ({hi_a, lo_a} !== 64'h0) begin
      errors++; $display("FAIL reset_mid_hilo got=%h_%h want=0_0", hi_a, lo_a);
    end
    reset = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge Clk);
      if (done_a) ndone++;
    end
    checks++; if (ndone != 0) begin errors++; $display("FAIL reset_mid_nodone got=%0d want=0", ndone); end
  endtask

  task automatic test_width8;
    int k;
    launch(2, OP_MULTU, 32'd255, 32'd255);
    wait_done(2, k);
    checks++; if (k != 9 || busy_c !== 1'b0) begin
      errors++; $display("FAIL w8_latency got=k%0d busy%0b want=k9 busy0", k, busy_c);
    end
    checks++; if ({hi_c, lo_c} !== 16'hFE01) begin
      errors++; $display("FAIL w8_multu got=%h_%h want=fe_01", hi_c, lo_c);
    end
    launch(2, OP_DIV, 32'h80, 32'hFF);
    wait_done(2, k);
    checks++; if ({hi_c, lo_c, dz_c} !== 17'b00000000_10000000_0) begin
      errors++; $display("FAIL w8_div_minbyneg1 got=%h_%h dz%0b want=00_80 dz0", hi_c, lo_c, dz_c);
    end
  endtask

  initial begin
    test_reset();
    test_multu();
    test_mult_signed();
    test_div();
    test_div_zero();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_width8();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
